// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   This is a multi-cycle shifter with a start/busy/done handshake.
//   - On a start pulse in IDLE it captures an operand, a shift mode and a shift
//     count. Counts above MAX_SHIFT are reduced to MAX_SHIFT.
//   - It then applies one single-bit shift per clock until the count runs out.
//   - It loads the result into data_out and pulses done for one cycle.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       operation request, sampled only in IDLE
//   data_in    in   DATA_W  operand, captured with start
//   mode       in   2       00 LSL, 01 LSR, 10 ASR, 11 ROL; captured with start
//   shift_cnt  in   CNT_W   number of single-bit shifts, captured with start
//   busy       out  1       high whenever the sequencer is not in IDLE
//   done       out  1       one-cycle pulse in the cycle data_out updates
//   data_out   out  DATA_W  result register; holds between operations
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  shift_cnt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // MAX_SHIFT is at most 2**CNT_W-1, so the reduced count fits in CNT_W bits.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] op_q,       op_d;
  logic [1:0]        mode_q,     mode_d;
  logic [CNT_W-1:0]  rem_q,      rem_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              done_q,     done_d;

  logic [CNT_W-1:0]  cnt_clamped;
  logic [DATA_W-1:0] op_shifted;

  assign cnt_clamped = (shift_cnt > MAX_CNT) ? MAX_CNT : shift_cnt;

  // One single-bit step of the captured operand under the captured mode.
  always_comb begin
    op_shifted = op_q;
    case (mode_q)
      MODE_LSL: op_shifted = {op_q[DATA_W-2:0], 1'b0};
      MODE_LSR: op_shifted = {1'b0, op_q[DATA_W-1:1]};
      MODE_ASR: op_shifted = {op_q[DATA_W-1], op_q[DATA_W-1:1]};
      MODE_ROL: op_shifted = {op_q[DATA_W-2:0], op_q[DATA_W-1]};
      default:  op_shifted = op_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = data_in;
          mode_d  = mode;
          rem_d   = cnt_clamped;
          state_d = (cnt_clamped != '0) ? ST_SHIFT : ST_OUT;
        end
      end

      ST_SHIFT: begin
        op_d  = op_shifted;
        rem_d = rem_q - 1'b1;
        // The test uses <= instead of ==. A zero count can never be held here,
        // so this only prevents a wrap if the register somehow holds zero.
        if (rem_q <= CNT_W'(1)) begin
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        data_out_d = op_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // An asynchronous reset aborts any operation in flight.
  // It clears data_out, and no done pulse is produced for the aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      mode_q     <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  // busy is decoded from registered state only. It is already low in the done
  // cycle, so a new start in that cycle is accepted.
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Purpose:
//   Directed testbench for shift_sequencer with the default parameters
//   (DATA_W=8, CNT_W=4, MAX_SHIFT=8).
//   - Each scenario task drives its own stimulus and checks its own results.
//   - Latency is counted in rising edges from the edge that samples start.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic [1:0] mode;
  logic [3:0] shift_cnt;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(
    .DATA_W   (8),
    .CNT_W    (4),
    .MAX_SHIFT(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .mode     (mode),
    .shift_cnt(shift_cnt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and measures it. This task only observes; every
  // comparison is made in the scenario task that calls it.
  //   lat        : edges from the start-sampling edge E up to the edge after
  //                which done is seen high (expected N+1)
  //   busy_e     : busy seen just after E
  //   busy_done  : busy seen in the done cycle
  //   busy_cyc   : number of sampled cycles with busy high
  // With scramble set, the task toggles start, data_in, mode and shift_cnt
  // on every cycle while the operation runs.
  task automatic run_op(input logic [7:0] d, input logic [1:0] m,
                        input logic [3:0] c, input bit scramble,
                        output int lat, output logic [7:0] res,
                        output logic busy_e, output logic busy_done,
                        output int busy_cyc);
    data_in   = d;
    mode      = m;
    shift_cnt = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_e   = busy;
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    while (!done && lat < 40) begin
      if (scramble) begin
        start     = 1'b1;
        data_in   = ~data_in;
        mode      = mode + 2'd1;
        shift_cnt = shift_cnt + 4'd3;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
    end
    start     = 1'b0;
    res       = data_out;
    busy_done = busy;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    data_in   = 8'h00;
    mode      = 2'b00;
    shift_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b data_out=%h, expected 0 0 00",
               busy, done, data_out);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b data_out=%h, expected 0 0 00",
               busy, done, data_out);
    end
    $display("test_reset: busy=%b done=%b data_out=%h", busy, done, data_out);
  endtask

  task automatic test_basic_lsl();
    int lat, bc;
    logic [7:0] res;
    logic be, bd;
    run_op(8'h81, 2'b00, 4'd1, 1'b0, lat, res, be, bd, bc);
    $display("test_basic_lsl: in=81 mode=00 cnt=1 -> out=%h lat=%0d", res, lat);
    checks++;
    if (be !== 1'b1) begin
      errors++; $display("FAIL lsl_busy_after_start: got %b, expected 1", be);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL lsl_latency: got %0d, expected 2", lat);
    end
    checks++;
    if (res !== 8'h02) begin
      errors++; $display("FAIL lsl_result: got %h, expected 02", res);
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++; $display("FAIL lsl_busy_at_done: got %b, expected 0", bd);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || data_out !== 8'h02) begin
      errors++;
      $display("FAIL lsl_done_pulse_hold: done=%b data_out=%h, expected 0 02", done, data_out);
    end
  endtask

  task automatic test_asr_rol();
    int lat, bc;
    logic [7:0] res;
    logic be, bd;
    run_op(8'h96, 2'b10, 4'd3, 1'b0, lat, res, be, bd, bc);
    $display("test_asr_rol: in=96 mode=10 cnt=3 -> out=%h lat=%0d", res, lat);
    checks++;
    if (res !== 8'hF2 || lat != 4) begin
      errors++; $display("FAIL asr3: got %h lat %0d, expected F2 lat 4", res, lat);
    end
    @(posedge clk); #1;
    run_op(8'h96, 2'b11, 4'd4, 1'b0, lat, res, be, bd, bc);
    $display("test_asr_rol: in=96 mode=11 cnt=4 -> out=%h lat=%0d", res, lat);
    checks++;
    if (res !== 8'h69 || lat != 5) begin
      errors++; $display("FAIL rol4: got %h lat %0d, expected 69 lat 5", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    int lat, bc;
    logic [7:0] res;
    logic be, bd;
    run_op(8'h5A, 2'b01, 4'd0, 1'b0, lat, res, be, bd, bc);
    $display("test_zero_count: in=5A mode=01 cnt=0 -> out=%h lat=%0d busy_cycles=%0d",
             res, lat, bc);
    checks++;
    if (res !== 8'h5A || lat != 1) begin
      errors++; $display("FAIL zero_cnt: got %h lat %0d, expected 5A lat 1", res, lat);
    end
    checks++;
    if (bc != 1) begin
      errors++; $display("FAIL zero_cnt_busy_cycles: got %0d, expected 1", bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int lat, bc;
    logic [7:0] res;
    logic be, bd;
    run_op(8'h96, 2'b11, 4'd15, 1'b0, lat, res, be, bd, bc);
    $display("test_saturate: in=96 mode=11 cnt=15 -> out=%h lat=%0d", res, lat);
    checks++;
    if (res !== 8'h96 || lat != 9) begin
      errors++; $display("FAIL sat_rol: got %h lat %0d, expected 96 lat 9", res, lat);
    end
    @(posedge clk); #1;
    run_op(8'h96, 2'b01, 4'd15, 1'b0, lat, res, be, bd, bc);
    $display("test_saturate: in=96 mode=01 cnt=15 -> out=%h lat=%0d", res, lat);
    checks++;
    if (res !== 8'h00 || lat != 9) begin
      errors++; $display("FAIL sat_lsr: got %h lat %0d, expected 00 lat 9", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat, bc, extra;
    logic [7:0] res;
    logic be, bd;
    // The inputs are scrambled while busy; the result must still be 96 >> 3.
    run_op(8'h96, 2'b01, 4'd3, 1'b1, lat, res, be, bd, bc);
    $display("test_busy_ignore: in=96 mode=01 cnt=3 scrambled -> out=%h lat=%0d", res, lat);
    checks++;
    if (res !== 8'h12 || lat != 4) begin
      errors++; $display("FAIL busy_ignore: got %h lat %0d, expected 12 lat 4", res, lat);
    end
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL busy_ignore_no_extra: got %0d active cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n_done, first, last, gap_bad, prev;
    data_in   = 8'h81;
    mode      = 2'b00;
    shift_cnt = 4'd2;
    start     = 1'b1;
    n_done = 0; first = -1; last = -1; gap_bad = 0; prev = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first < 0) first = cyc;
        if (prev >= 0 && cyc - prev != 4) gap_bad++;
        if (data_out !== 8'h04) gap_bad++;
        prev = cyc;
        last = cyc;
      end
    end
    start = 1'b0;
    $display("test_back_to_back: dones=%0d first=%0d last=%0d bad=%0d",
             n_done, first, last, gap_bad);
    checks++;
    if (n_done != 3 || first != 4 || last != 12) begin
      errors++;
      $display("FAIL back_to_back_rate: dones=%0d first=%0d last=%0d, expected 3 4 12",
               n_done, first, last);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL back_to_back_spacing_data: got %0d bad, expected 0", gap_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int stray;
    data_in   = 8'h96;
    mode      = 2'b00;
    shift_cnt = 4'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || data_out === 8'h00) begin
      errors++;
      $display("FAIL abort_precondition: busy=%b data_out=%h, expected busy 1 and nonzero",
               busy, data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("test_async_reset: mid-shift reset -> busy=%b done=%b data_out=%h",
             busy, done, data_out);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_immediate: busy=%b done=%b data_out=%h, expected 0 0 00",
               busy, done, data_out);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy || data_out !== 8'h00) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d active cycles, expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lsl();
    test_asr_rol();
    test_zero_count();
    test_saturate();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
